// File: rtl/mem_arbiter.sv
// Round-robin sharer of one SRAM port between boot/debug (A) and core (B); all outputs registered.
// Latency: grant edge + WAIT_CYCLES+1 strobe cycles, ack the cycle after; losers hold req (no queueing).
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_reqA,
    input  logic              i_wrA,
    input  logic [ADDR_W-1:0] i_addrA,
    input  logic [DATA_W-1:0] i_dataA,
    output logic              o_ackA,
    output logic [DATA_W-1:0] o_dataA,
    input  logic              i_reqB,
    input  logic              i_wrB,
    input  logic [ADDR_W-1:0] i_addrB,
    input  logic [DATA_W-1:0] i_dataB,
    output logic              o_ackB,
    output logic [DATA_W-1:0] o_dataB,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memWrData,
    output logic              o_memWr,
    output logic              o_memEn,
    input  logic [DATA_W-1:0] i_memRdData,
    output logic              o_busy
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_b_q, last_b_d;
    logic                gnt_b_q, gnt_b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                en_q, en_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DATA_W-1:0]   data_a_q, data_a_d;
    logic [DATA_W-1:0]   data_b_q, data_b_d;
    logic                busy_q, busy_d;
    logic                pick_b;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        gnt_b_d  = gnt_b_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        en_d     = en_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        pick_b   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_reqA || i_reqB) begin
                    // On a tie, B wins only if A was served last.
                    pick_b   = i_reqB && (!i_reqA || !last_b_q);
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    addr_d   = pick_b ? i_addrB : i_addrA;
                    wdata_d  = pick_b ? i_dataB : i_dataA;
                    wr_d     = pick_b ? i_wrB : i_wrA;
                    en_d     = 1'b1;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    en_d = 1'b0;
                    wr_d = 1'b0;
                    if (!wr_q) begin
                        if (gnt_b_q) data_b_d = i_memRdData;
                        else         data_a_d = i_memRdData;
                    end
                    ack_a_d = !gnt_b_q;
                    ack_b_d = gnt_b_q;
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            gnt_b_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            en_q     <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            gnt_b_q  <= gnt_b_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            en_q     <= en_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            busy_q   <= busy_d;
        end
    end

    assign o_ackA      = ack_a_q;
    assign o_ackB      = ack_b_q;
    assign o_dataA     = data_a_q;
    assign o_dataB     = data_b_q;
    assign o_memAddr   = addr_q;
    assign o_memWrData = wdata_q;
    assign o_memWr     = wr_q;
    assign o_memEn     = en_q;
    assign o_busy      = busy_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single external SRAM port between two requesters.
  - Port A: boot/debug, i.e. the EEPROM boot copy and JTAG memory access.
  - Port B: core load/store/fetch.
- Round-robin arbitration with a fixed access window of WAIT_CYCLES+1 cycles per transfer.
- Drives the unidirectional SRAM-side signals. Tri-state and active-low conversion stay in the chassis.

Parameters:
ADDR_W, 16, address width of both requesters and SRAM port
DATA_W, 16, data width
WAIT_CYCLES, 1, extra cycles the SRAM strobe is held beyond the first (0 allowed)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_reqA  in  1  port A request; held until o_ackA
i_wrA  in  1  port A write(1)/read(0)
i_addrA  in  ADDR_W  port A address
i_dataA  in  DATA_W  port A write data
o_ackA  out  1  one-cycle completion pulse, port A
o_dataA  out  DATA_W  port A read data, valid with o_ackA
i_reqB, i_wrB, i_addrB, i_dataB, o_ackB, o_dataB  (same as A, for port B)
o_memAddr  out  ADDR_W  SRAM address
o_memWrData  out  DATA_W  SRAM write data
o_memWr  out  1  SRAM write strobe (1 = write)
o_memEn  out  1  SRAM enable
i_memRdData  in  DATA_W  SRAM read data
o_busy  out  1  high in ACCESS and RECOVER states

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; all outputs = 0; lastGrant = B, so A wins the first tie.
  - Any in-flight access is abandoned; no ack is issued.
- All outputs are registered. No combinational path from any input to any output.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Exactly one request: grant it.
    - Both request: grant the port that is not lastGrant.
    - On grant: latch addr/wr/data of the winner into the o_mem* registers; set o_memEn = 1; o_memWr = winner's wr; cnt = WAIT_CYCLES; lastGrant = winner; go to ACCESS.
  - ACCESS:
    - o_memEn is held; address, data and wr are stable for the whole state.
    - If cnt != 0: decrement cnt.
    - If cnt == 0:
      - Clear o_memEn and o_memWr.
      - Read: capture i_memRdData into o_dataX of the granted port. Write: leave o_dataX unchanged.
      - Set o_ackX = 1; go to RECOVER.
  - RECOVER:
    - o_ackX is high for exactly this cycle; o_memEn = 0; no arbitration.
    - Next state is IDLE, with o_ackX cleared.
- Timing (request sampled in IDLE at edge E0):
  - o_memEn is high for cycles E0+1 .. E0+1+WAIT_CYCLES.
  - Ack arrives in cycle E0+2+WAIT_CYCLES.
  - Earliest next grant is at the edge after that.
  - Throughput: one access per WAIT_CYCLES+3 cycles.
- Requester rules:
  - Address, data and wr must be stable from the request until the ack. The arbiter latches them at grant and ignores later changes.
  - Requester drops req in the cycle after seeing ack, or keeps req high to issue a new request; a new request is recognised at the first IDLE cycle.
  - Req dropped mid-access: the access still completes and the ack is still pulsed.
- o_memAddr and o_memWrData keep their last values after an access completes. They are only meaningful while o_memEn = 1.
- Counter width = max(1, clog2(WAIT_CYCLES+1)). No wrap: the counter is loaded only in IDLE.
- Fairness: with both ports requesting continuously, grants alternate A, B, A, B. Neither port waits more than one foreign access.

Test Plan:
- Reset, then single read on A: WAIT_CYCLES=1, reqA at addr 0x1234 with SRAM model returning 0xBEEF.
  - Expect o_memEn high for exactly 2 cycles with o_memAddr = 0x1234 and o_memWr = 0.
  - Expect o_ackA one cycle later with o_dataA = 0xBEEF; o_ackB never asserts.
- Write on B: addr 0x0042, data 0xA5A5.
  - Expect o_memWr = 1, o_memWrData = 0xA5A5 for 2 cycles, then o_ackB.
  - o_dataB is unchanged.
- Simultaneous continuous reqA and reqB from reset for 4 accesses:
  - Grant order A, B, A, B.
  - Each access takes 4 cycles; no cycle has both acks high.
- WAIT_CYCLES=0 build, read on A: o_memEn high for 1 cycle; ack 2 cycles after the request is sampled.
- Assert i_rst asynchronously in the middle of ACCESS of a B write:
  - All outputs go to 0 immediately; no o_ackB is issued.
  - After reset, a pending reqA and reqB tie is granted to A first.
- Change i_addrA during ACCESS from 0x0010 to 0x0020: o_memAddr stays 0x0010 for the whole access.
